ps2_byte_receiver: RTL and testbench

// - Receive PS/2 device-to-host frames: 1 start, 8 data (LSB first), odd parity, 1 stop.
// - Sits inside the mouse transceiver, upstream of the mouse master state machine.
// - Delivers one byte per frame with a 1-cycle BYTE_READY strobe and an error code.
// - The master state machine assembles 3/4-byte mouse packets from these bytes.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_clk_filter.sv | 56 +++++
 rtl/ps2_byte_receiver.sv | 130 +++++++++++++
 tb/tb_ps2_byte_receiver.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: receiver state encoding, error-code bit positions,
// default timing parameters and well-known device byte values.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    localparam int ERR_PARITY = 0;
    localparam int ERR_STOP   = 1;

    localparam int DEF_FILTER_LEN     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 50000;

    localparam logic [7:0] PS2_ACK     = 8'hFA;
    localparam logic [7:0] PS2_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_SELF_OK = 8'hAA;

    // PS/2 uses odd parity, so a frame is in error when its total ones count is even
    function automatic logic parity_error(input logic [7:0] data, input logic parity_bit);
        return ~^{data, parity_bit};
    endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronises the raw PS/2 lines, glitch-filters the clock and emits a
// one-cycle strobe on each filtered clock falling edge.
module ps2_clk_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clk_raw,
    input  logic data_raw,
    output logic data_sync,
    output logic fall_strobe
);

    logic                  clk_meta_q, clk_sync_q;
    logic                  data_meta_q, data_sync_q;
    logic [FILTER_LEN-1:0] hist_q, hist_d;
    logic                  clk_filt_q, clk_filt_d;
    logic                  strobe_q, strobe_d;

    always_comb begin
        hist_d     = {hist_q[FILTER_LEN-2:0], clk_sync_q};
        clk_filt_d = clk_filt_q;
        // Only a full window of agreeing samples may move the filtered clock
        if (hist_q == '0)
            clk_filt_d = 1'b0;
        else if (&hist_q)
            clk_filt_d = 1'b1;
        strobe_d = clk_filt_q & ~clk_filt_d;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
            hist_q      <= '1;
            clk_filt_q  <= 1'b1;
            strobe_q    <= 1'b0;
        end else begin
            clk_meta_q  <= clk_raw;
            clk_sync_q  <= clk_meta_q;
            data_meta_q <= data_raw;
            data_sync_q <= data_meta_q;
            hist_q      <= hist_d;
            clk_filt_q  <= clk_filt_d;
            strobe_q    <= strobe_d;
        end
    end

    assign data_sync   = data_sync_q;
    assign fall_strobe = strobe_q;

endmodule

// File: rtl/ps2_byte_receiver.sv
// PS/2 device-to-host byte receiver: start, 8 data bits LSB first, odd parity,
// stop. Delivers each byte with a one-cycle ready strobe and an error code.
module ps2_byte_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       READ_ENABLE,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    output logic [7:0] BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       BYTE_READY,
    output logic       FRAME_BUSY
);

    localparam int              TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic data_sync, strobe;

    ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
        .CLK        (CLK),
        .RESET      (RESET),
        .clk_raw    (CLK_MOUSE_IN),
        .data_raw   (DATA_MOUSE_IN),
        .data_sync  (data_sync),
        .fall_strobe(strobe)
    );

    ps2_state_e    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_err_q, par_err_d;
    logic [7:0]    byte_q, byte_d;
    logic [1:0]    err_q, err_d;
    logic          ready_q, ready_d;
    logic [TW-1:0] tmo_q, tmo_d;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_err_d = par_err_q;
        byte_d    = byte_q;
        err_d     = err_q;
        ready_d   = 1'b0;
        tmo_d     = tmo_q;

        if (!READ_ENABLE) begin
            state_d = ST_IDLE;
            tmo_d   = '0;
        end else begin
            if (state_q == ST_IDLE || strobe)
                tmo_d = '0;
            else
                tmo_d = tmo_q + 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (strobe && !data_sync) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                ST_DATA: begin
                    if (strobe) begin
                        shift_d   = {data_sync, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7)
                            state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (strobe) begin
                        par_err_d = parity_error(shift_q, data_sync);
                        state_d   = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (strobe) begin
                        ready_d            = 1'b1;
                        byte_d             = shift_q;
                        err_d[ERR_PARITY]  = par_err_q;
                        err_d[ERR_STOP]    = ~data_sync;
                        state_d            = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            // A stalled device abandons the partial byte; delivered outputs are untouched
            if (state_q != ST_IDLE && !strobe && tmo_q == TMO_LAST) begin
                state_d = ST_IDLE;
                tmo_d   = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            par_err_q <= 1'b0;
            byte_q    <= 8'h00;
            err_q     <= 2'b00;
            ready_q   <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_err_q <= par_err_d;
            byte_q    <= byte_d;
            err_q     <= err_d;
            ready_q   <= ready_d;
            tmo_q     <= tmo_d;
        end
    end

    assign BYTE_READ       = byte_q;
    assign BYTE_ERROR_CODE = err_q;
    assign BYTE_READY      = ready_q;
    assign FRAME_BUSY      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_byte_receiver.sv
// Scoreboard bench for ps2_byte_receiver: directed PS/2 frames with expected
// bytes queued at issue time and checked by an independent ready monitor.
module tb_ps2_byte_receiver;

    localparam int HALF_BIT = 40;   // cycles per PS/2 clock phase

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       READ_ENABLE = 1'b1;
    logic       CLK_MOUSE_IN = 1'b1;
    logic       DATA_MOUSE_IN = 1'b1;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;
    logic       FRAME_BUSY;

    ps2_byte_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(2000)) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .READ_ENABLE    (READ_ENABLE),
        .CLK_MOUSE_IN   (CLK_MOUSE_IN),
        .DATA_MOUSE_IN  (DATA_MOUSE_IN),
        .BYTE_READ      (BYTE_READ),
        .BYTE_ERROR_CODE(BYTE_ERROR_CODE),
        .BYTE_READY     (BYTE_READY),
        .FRAME_BUSY     (FRAME_BUSY)
    );

    always #500 CLK = ~CLK;

    typedef struct packed {
        logic [7:0] b;
        logic [1:0] err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every BYTE_READY pulse must match the oldest expected byte
    always @(negedge CLK) begin
        if (!RESET && BYTE_READY) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ready", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("byte_read", {24'd0, BYTE_READ}, {24'd0, e.b});
                check("byte_err", {30'd0, BYTE_ERROR_CODE}, {30'd0, e.err});
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // One PS/2 bit: data set during high, then clock low/high; optional 5-cycle glitch while high
    task automatic ps2_bit(input logic b, input logic glitch);
        DATA_MOUSE_IN = b;
        wait_cyc(HALF_BIT / 2);
        CLK_MOUSE_IN = 1'b0;
        wait_cyc(HALF_BIT);
        CLK_MOUSE_IN = 1'b1;
        if (glitch) begin
            wait_cyc(10);
            CLK_MOUSE_IN = 1'b0;
            wait_cyc(5);
            CLK_MOUSE_IN = 1'b1;
            wait_cyc(HALF_BIT / 2 - 15);
        end else begin
            wait_cyc(HALF_BIT / 2);
        end
    endtask

    // Sends the first nbits of frame {stop, parity, data, start}
    task automatic send_bits(input logic [7:0] data, input logic par, input logic stop,
                             input int nbits, input int glitch_at);
        logic [10:0] fr;
        fr = {stop, par, data, 1'b0};
        for (int i = 0; i < nbits; i++)
            ps2_bit(fr[i], i == glitch_at);
        DATA_MOUSE_IN = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic par, input logic stop,
                              input logic [1:0] exp_err, input int glitch_at);
        exp_t e;
        e.b = data;
        e.err = exp_err;
        exp_q.push_back(e);
        send_bits(data, par, stop, 11, glitch_at);
        wait_cyc(60);
    endtask

    initial begin
        wait_cyc(5);
        check("rst_byte", {24'd0, BYTE_READ}, 32'h00);
        check("rst_err", {30'd0, BYTE_ERROR_CODE}, 32'h0);
        check("rst_ready", {31'd0, BYTE_READY}, 32'h0);
        check("rst_busy", {31'd0, FRAME_BUSY}, 32'h0);
        RESET = 1'b0;
        wait_cyc(20);

        // 1-3: clean, parity error, stop error
        send_frame(8'hFA, 1'b1, 1'b1, 2'b00, -1);
        send_frame(8'h08, 1'b1, 1'b1, 2'b01, -1);
        send_frame(8'h55, 1'b1, 1'b0, 2'b10, -1);
        check("hold_byte", {24'd0, BYTE_READ}, 32'h55);
        check("hold_err", {30'd0, BYTE_ERROR_CODE}, 32'h2);

        // 4: stall after start + 4 data bits, then a clean frame
        send_bits(8'hAA, 1'b1, 1'b1, 5, -1);
        check("stall_busy", {31'd0, FRAME_BUSY}, 32'h1);
        wait_cyc(2500);
        check("timeout_busy", {31'd0, FRAME_BUSY}, 32'h0);
        check("timeout_hold", {24'd0, BYTE_READ}, 32'h55);
        send_frame(8'hAA, 1'b1, 1'b1, 2'b00, -1);

        // 5: idle glitch and mid-byte glitch
        CLK_MOUSE_IN = 1'b0;
        wait_cyc(5);
        CLK_MOUSE_IN = 1'b1;
        wait_cyc(30);
        check("glitch_idle_busy", {31'd0, FRAME_BUSY}, 32'h0);
        send_frame(8'h3C, 1'b1, 1'b1, 2'b00, 4);

        // 6a: READ_ENABLE drop after bit 3, remainder of frame ignored
        send_bits(8'h81, 1'b1, 1'b1, 4, -1);
        check("pre_abort_busy", {31'd0, FRAME_BUSY}, 32'h1);
        READ_ENABLE = 1'b0;
        wait_cyc(2);
        check("abort_busy", {31'd0, FRAME_BUSY}, 32'h0);
        send_bits(8'h81, 1'b1, 1'b1, 11, -1);
        wait_cyc(40);
        READ_ENABLE = 1'b1;
        wait_cyc(20);

        // 6b: RESET mid-frame, then a clean frame
        send_bits(8'h81, 1'b1, 1'b1, 6, -1);
        RESET = 1'b1;
        wait_cyc(3);
        check("midrst_byte", {24'd0, BYTE_READ}, 32'h00);
        check("midrst_err", {30'd0, BYTE_ERROR_CODE}, 32'h0);
        check("midrst_busy", {31'd0, FRAME_BUSY}, 32'h0);
        check("midrst_ready", {31'd0, BYTE_READY}, 32'h0);
        RESET = 1'b0;
        wait_cyc(20);
        send_frame(8'hF4, 1'b0, 1'b1, 2'b00, -1);

        for (int i = 0; i < 200 && exp_q.size() != 0; i++)
            wait_cyc(1);
        check("all_bytes_seen", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
